vga_frame_scanner: RTL and testbench

Parametrised VGA scan engine that replaces the fixed 640x480 timing/readout path in VeggieVik.
- Derives a pixel-tick enable from CLOCK_50.
- Generates HS/VS/BLANK_N and DrawX/DrawY.
- Issues frame-buffer read addresses, in 1x mode or 2x pixel-doubled (320x240 buffer) mode.
- Registers returned palette indices so that pixel data, sync and blank leave the block aligned.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_addr_gen.sv | 62 ++++++
 rtl/vga_frame_scanner.sv | 137 +++++++++++++
 tb/tb_vga_frame_scanner.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing types and helpers.
// Default constants describe 640x480@60 with a 25 MHz pixel tick.
package vga_pkg;

  typedef struct packed {
    logic [15:0] visible;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } vga_timing_t;

  function automatic int h_total(vga_timing_t t);
    return int'(t.visible) + int'(t.fp) + int'(t.sync) + int'(t.bp);
  endfunction

  function automatic int v_total(vga_timing_t t);
    return int'(t.visible) + int'(t.fp) + int'(t.sync) + int'(t.bp);
  endfunction

  localparam vga_timing_t VGA_H_640 = '{
    visible: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48
  };

  localparam vga_timing_t VGA_V_480 = '{
    visible: 16'd480, fp: 16'd10, sync: 16'd2, bp: 16'd33
  };

endpackage

// File: rtl/vga_addr_gen.sv
// Frame-buffer address generator: incremental line base plus column,
// with a per-frame 1x / 2x pixel-doubling mode latch.
module vga_addr_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = 640,
  parameter int HW        = 10,
  parameter int ADDR_W    = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic              frame_start,
  input  logic              scale_2x,
  input  logic              line_end,
  input  logic              frame_end,
  input  logic              vis_line,
  input  logic              line_odd,
  input  logic              nxt_vis,
  input  logic [HW-1:0]     h_next,
  output logic [ADDR_W-1:0] rd_addr
);

  logic              mode_q;
  logic              mode_eff;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] base_nxt;
  logic [ADDR_W-1:0] stride;
  logic [ADDR_W-1:0] col;

  // The address is issued for the position the counters move to, so the
  // mode being latched this tick must already steer the column.
  always_comb begin
    mode_eff = frame_start ? scale_2x : mode_q;
    stride   = mode_q ? ADDR_W'(H_VISIBLE / 2)
                      : ADDR_W'(H_VISIBLE);
    base_nxt = line_base;
    if (frame_end) begin
      base_nxt = '0;
    end else if (line_end && vis_line && (!mode_q || line_odd)) begin
      base_nxt = line_base + stride;
    end
    col = mode_eff ? ADDR_W'(h_next >> 1) : ADDR_W'(h_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= 1'b0;
      line_base <= '0;
      rd_addr   <= '0;
    end else if (pix_en) begin
      if (frame_start) begin
        mode_q <= scale_2x;
      end
      line_base <= base_nxt;
      if (nxt_vis) begin
        rd_addr <= base_nxt + col;
      end
    end
  end

endmodule

// File: rtl/vga_frame_scanner.sv
// Parametrised VGA scan engine: tick divider, H/V counters, sync/blank
// generation and a one-tick output stage aligned with frame-buffer data.
module vga_frame_scanner
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = int'(VGA_H_640.visible),
  parameter int H_FP      = int'(VGA_H_640.fp),
  parameter int H_SYNC    = int'(VGA_H_640.sync),
  parameter int H_BP      = int'(VGA_H_640.bp),
  parameter int V_VISIBLE = int'(VGA_V_480.visible),
  parameter int V_FP      = int'(VGA_V_480.fp),
  parameter int V_SYNC    = int'(VGA_V_480.sync),
  parameter int V_BP      = int'(VGA_V_480.bp),
  parameter int CLK_DIV   = 2,
  parameter int RD_LAT    = 1,
  parameter int ADDR_W    = 19,
  parameter int PIX_W     = 8
) (
  input  logic              CLOCK_50,
  input  logic              Reset,
  input  logic              scale_2x,
  input  logic [PIX_W-1:0]  frame_output,
  output logic [ADDR_W-1:0] frame_rdAddress,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              pix_en,
  output logic [9:0]        DrawX_OUT,
  output logic [9:0]        DrawY_OUT,
  output logic              frame_start
);

  localparam vga_timing_t HT = '{
    visible: 16'(H_VISIBLE), fp: 16'(H_FP),
    sync: 16'(H_SYNC), bp: 16'(H_BP)
  };
  localparam vga_timing_t VT = '{
    visible: 16'(V_VISIBLE), fp: 16'(V_FP),
    sync: 16'(V_SYNC), bp: 16'(V_BP)
  };
  localparam int H_TOTAL = h_total(HT);
  localparam int V_TOTAL = v_total(VT);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(CLK_DIV);
  localparam int HS_BEG  = H_VISIBLE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_VISIBLE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  if (CLK_DIV < 2 || RD_LAT >= CLK_DIV ||
      (H_VISIBLE % 2) != 0 || (V_VISIBLE % 2) != 0 ||
      longint'(H_VISIBLE) * longint'(V_VISIBLE) >
      (longint'(1) << ADDR_W)) begin : g_bad_cfg
    $error("vga_frame_scanner: invalid parameter set");
  end

  logic [DW-1:0] div;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] h_next;
  logic [VW-1:0] vcnt;
  logic [VW-1:0] v_next;
  logic          line_end;
  logic          frame_end;
  logic          visible;
  logic          nxt_vis;
  logic          hs0;
  logic          vs0;

  assign pix_en      = div == DW'(CLK_DIV - 1);
  assign frame_start = pix_en && hcnt == '0 && vcnt == '0;

  always_comb begin
    line_end  = int'(hcnt) == H_TOTAL - 1;
    frame_end = line_end && int'(vcnt) == V_TOTAL - 1;
    h_next    = line_end ? '0 : hcnt + 1'b1;
    v_next    = vcnt;
    if (frame_end) begin
      v_next = '0;
    end else if (line_end) begin
      v_next = vcnt + 1'b1;
    end
    visible = int'(hcnt) < H_VISIBLE && int'(vcnt) < V_VISIBLE;
    nxt_vis = int'(h_next) < H_VISIBLE && int'(v_next) < V_VISIBLE;
    hs0 = !(int'(hcnt) >= HS_BEG && int'(hcnt) < HS_END);
    vs0 = !(int'(vcnt) >= VS_BEG && int'(vcnt) < VS_END);
  end

  vga_addr_gen #(
    .H_VISIBLE (H_VISIBLE),
    .HW        (HW),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .clk         (CLOCK_50),
    .rst         (Reset),
    .pix_en      (pix_en),
    .frame_start (frame_start),
    .scale_2x    (scale_2x),
    .line_end    (line_end),
    .frame_end   (frame_end),
    .vis_line    (int'(vcnt) < V_VISIBLE),
    .line_odd    (vcnt[0]),
    .nxt_vis     (nxt_vis),
    .h_next      (h_next),
    .rd_addr     (frame_rdAddress)
  );

  // frame_output holds the data for the current position by the closing
  // tick edge, so sync/blank/coords are registered on the same edge.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      div         <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      pixel_out   <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      DrawX_OUT   <= '0;
      DrawY_OUT   <= '0;
    end else begin
      div <= pix_en ? '0 : div + 1'b1;
      if (pix_en) begin
        hcnt        <= h_next;
        vcnt        <= v_next;
        pixel_out   <= visible ? frame_output : '0;
        VGA_HS      <= hs0;
        VGA_VS      <= vs0;
        VGA_BLANK_N <= visible;
        DrawX_OUT   <= visible ? 10'(hcnt) : '0;
        DrawY_OUT   <= visible ? 10'(vcnt) : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Bench for vga_frame_scanner on a reduced 16x6 raster: tick-level
// reference model checked every clock plus literal spot values.
module tb_vga_frame_scanner;

  localparam int HV    = 16;
  localparam int HFP   = 2;
  localparam int HSW   = 4;
  localparam int HBP   = 2;
  localparam int VV    = 6;
  localparam int VFP   = 1;
  localparam int VSW   = 2;
  localparam int VBP   = 1;
  localparam int CD    = 2;
  localparam int AW    = 10;
  localparam int PW    = 8;
  localparam int HT    = HV + HFP + HSW + HBP;
  localparam int VT    = VV + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s2x = 1'b0;
  logic [PW-1:0] fb_data = '0;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] pix;
  logic          hs, vs, bn, pe, fs;
  logic [9:0]    dx, dy;

  always #5 clk = ~clk;

  vga_frame_scanner #(
    .H_VISIBLE (HV), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_VISIBLE (VV), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .CLK_DIV (CD), .RD_LAT (1), .ADDR_W (AW), .PIX_W (PW)
  ) dut (
    .CLOCK_50        (clk),
    .Reset           (rst),
    .scale_2x        (s2x),
    .frame_output    (fb_data),
    .frame_rdAddress (rd_addr),
    .pixel_out       (pix),
    .VGA_HS          (hs),
    .VGA_VS          (vs),
    .VGA_BLANK_N     (bn),
    .pix_en          (pe),
    .DrawX_OUT       (dx),
    .DrawY_OUT       (dy),
    .frame_start     (fs)
  );

  // Frame buffer returns the low address byte one clock later.
  always @(posedge clk) fb_data <= rd_addr[7:0];

  logic rst_seen, s2x_seen;
  always @(posedge clk) begin
    rst_seen <= rst;
    s2x_seen <= s2x;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit vis(int h, int v);
    return h < HV && v < VV;
  endfunction

  function automatic int addr_of(int h, int v, bit m);
    return m ? (v / 2) * (HV / 2) + h / 2 : v * HV + h;
  endfunction

  int k = 0, p = 0, seg = 0, m_addr = 0;
  bit m_mode = 0, prev_rst = 0;

  int first_pe = -1, fs1 = -1, fs2 = -1, fs_seg2 = -1;
  int hs_first = -1, hs_cnt = 0, vs_first = -1, vs_cnt = 0;
  int bl_first = -1, bl_last = -1, bl_cnt = 0;
  int pix_5_2 = -1, pix2x_5_2 = -1, a1x_5_4 = -1;
  int a2x_15_1 = -1, a2x_0_2 = -1, a2x_15_5 = -1;
  int rst_addr = -1, rst_bn = -1;

  always @(negedge clk) begin
    int q, h, v, oq, oh, ov, f;
    bit epe, efs, ovis;
    if (rst_seen) begin
      if (!prev_rst) begin
        seg++;
        if (seg == 2) begin
          rst_addr = int'(rd_addr);
          rst_bn   = int'(bn);
        end
      end
      k = 0; p = 0; m_mode = 0; m_addr = 0;
    end else begin
      k++;
      if (k % CD == 0) begin
        if (p % FRAME == 0) m_mode = s2x_seen;
        p++;
        q = p % FRAME; h = q % HT; v = q / HT;
        if (vis(h, v)) m_addr = addr_of(h, v, m_mode);
      end
    end
    prev_rst = rst_seen;

    epe = !rst_seen && (k % CD == CD - 1);
    efs = epe && (p % FRAME == 0);
    chk("pix_en", pe, epe);
    chk("frame_start", fs, efs);
    chk("frame_rdAddress", rd_addr, m_addr);
    if (p == 0) begin
      chk("pixel_out", pix, 0);
      chk("VGA_HS", hs, 1);
      chk("VGA_VS", vs, 1);
      chk("VGA_BLANK_N", bn, 0);
      chk("DrawX_OUT", dx, 0);
      chk("DrawY_OUT", dy, 0);
    end else begin
      oq = (p - 1) % FRAME; oh = oq % HT; ov = oq / HT;
      ovis = vis(oh, ov);
      chk("pixel_out", pix,
          ovis ? (addr_of(oh, ov, m_mode) & 255) : 0);
      chk("VGA_HS", hs, !(oh >= HV + HFP && oh < HV + HFP + HSW));
      chk("VGA_VS", vs, !(ov >= VV + VFP && ov < VV + VFP + VSW));
      chk("VGA_BLANK_N", bn, ovis);
      chk("DrawX_OUT", dx, ovis ? oh : 0);
      chk("DrawY_OUT", dy, ovis ? ov : 0);
    end

    if (seg == 1 && pe && first_pe < 0) first_pe = k;
    if (fs && !rst_seen) begin
      if (seg == 1 && fs1 < 0) fs1 = k;
      else if (seg == 1 && fs2 < 0) fs2 = k;
      else if (seg == 2 && fs_seg2 < 0) fs_seg2 = k;
    end
    if (seg == 1 && epe && p >= 1 && p <= HT) begin
      if (!hs) begin
        if (hs_first < 0) hs_first = p;
        hs_cnt++;
      end
      if (bn) begin
        if (bl_first < 0) bl_first = p;
        bl_last = p;
        bl_cnt++;
      end
    end
    if (seg == 1 && epe && p >= 1 && p <= FRAME && !vs) begin
      if (vs_first < 0) vs_first = p;
      vs_cnt++;
    end
    if (seg == 1 && epe) begin
      q = p % FRAME; h = q % HT; v = q / HT; f = p / FRAME;
      if (f == 1 && h == 5 && v == 4) a1x_5_4 = int'(rd_addr);
      if (f == 2 && h == 15 && v == 1) a2x_15_1 = int'(rd_addr);
      if (f == 2 && h == 0 && v == 2) a2x_0_2 = int'(rd_addr);
      if (f == 2 && h == 15 && v == 5) a2x_15_5 = int'(rd_addr);
      if (p >= 1 && bn && dx == 10'd5 && dy == 10'd2) begin
        if ((p - 1) / FRAME == 0) pix_5_2 = int'(pix);
        if ((p - 1) / FRAME == 2) pix2x_5_2 = int'(pix);
      end
    end
  end

  initial begin
    rst = 1'b1;
    s2x = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    // frame 1 runs 1x; switch requested mid-frame
    repeat (624) @(posedge clk);
    #2 s2x = 1'b1;
    // frame 2 runs 2x; switch back requested mid-frame
    repeat (576) @(posedge clk);
    #2 s2x = 1'b0;
    // one-clock reset at hcnt=10, vcnt=3 of frame 3
    repeat (404) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (700) @(posedge clk);
    @(negedge clk);
    #1;
    chk("first_pix_en_clock", first_pe, 1);
    chk("first_frame_start_clock", fs1, 1);
    chk("frame_period_clocks", fs2 - fs1, 480);
    chk("hs_low_first_tick", hs_first, 19);
    chk("hs_low_ticks", hs_cnt, 4);
    chk("blank_n_first_tick", bl_first, 1);
    chk("blank_n_last_tick", bl_last, 16);
    chk("blank_n_ticks", bl_cnt, 16);
    chk("vs_low_first_tick", vs_first, 169);
    chk("vs_low_ticks", vs_cnt, 48);
    chk("pix_1x_x5_y2", pix_5_2, 37);
    chk("addr_1x_after_toggle", a1x_5_4, 69);
    chk("addr_2x_line1_end", a2x_15_1, 7);
    chk("addr_2x_line2_start", a2x_0_2, 8);
    chk("addr_2x_last_visible", a2x_15_5, 23);
    chk("pix_2x_x5_y2", pix2x_5_2, 10);
    chk("addr_after_mid_reset", rst_addr, 0);
    chk("blank_n_after_mid_reset", rst_bn, 0);
    chk("frame_start_after_restart", fs_seg2, 1);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
